operand_fetch: RTL

- Read-side sequencer for the 32x32 register file: takes decoded instruction fields, drives the file's read addresses, captures the operands and presents them to the ALU stage over a valid/ready handshake.
- Keeps a 32-entry busy scoreboard of registers with a write still outstanding.
- Bypasses the same-cycle writeback value (ALUout), and stalls on RAW/WAW hazards that bypass cannot resolve.

---
 rtl/operand_fetch_if.sv | 36 +++
 rtl/operand_fetch.sv | 65 ++++++
 2 files changed

// File: rtl/operand_fetch_if.sv
// operand_fetch_if: decode, register-file read, writeback and ALU-issue signals of the operand fetch stage
interface operand_fetch_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_srcadd1;
  logic [ADDR_W-1:0] in_srcadd2;
  logic [ADDR_W-1:0] in_destadd;
  logic              in_wen;
  logic [ADDR_W-1:0] srcadd1;
  logic [ADDR_W-1:0] srcadd2;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_destadd;
  logic [DATA_W-1:0] ALUout;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic [ADDR_W-1:0] out_destadd;
  logic              out_wen;
  logic              wb_err;
  modport slave (
    input  in_valid, in_srcadd1, in_srcadd2, in_destadd, in_wen, src1, src2,
           wb_valid, wb_destadd, ALUout, out_ready,
    output in_ready, srcadd1, srcadd2, out_valid, op1, op2, out_destadd, out_wen, wb_err
  );
  modport master (
    output in_valid, in_srcadd1, in_srcadd2, in_destadd, in_wen, src1, src2,
           wb_valid, wb_destadd, ALUout, out_ready,
    input  in_ready, srcadd1, srcadd2, out_valid, op1, op2, out_destadd, out_wen, wb_err
  );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: register-file read sequencer with busy scoreboard, writeback bypass and RAW/WAW stall
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic clk,
  input logic rst,
  operand_fetch_if.slave bus_io
);
  localparam int NREG = 2 ** ADDR_W;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic              wen_q, wen_d;
  logic              wb_err_q, wb_err_d;
  logic              byp1, byp2, bypd, hazard, ready, accept;
  always_comb begin
    byp1   = bus_io.wb_valid && bus_io.wb_destadd == bus_io.in_srcadd1;
    byp2   = bus_io.wb_valid && bus_io.wb_destadd == bus_io.in_srcadd2;
    bypd   = bus_io.wb_valid && bus_io.wb_destadd == bus_io.in_destadd;
    hazard = (busy_q[bus_io.in_srcadd1] && !byp1) || (busy_q[bus_io.in_srcadd2] && !byp2) ||
             (bus_io.in_wen && busy_q[bus_io.in_destadd] && !bypd);
    ready  = !hazard && (!out_valid_q || bus_io.out_ready);
    accept = bus_io.in_valid && ready;
    busy_d = busy_q;
    // Clear first so a same-cycle new write to the same register keeps it busy
    if (bus_io.wb_valid) busy_d[bus_io.wb_destadd] = 1'b0;
    if (accept && bus_io.in_wen) busy_d[bus_io.in_destadd] = 1'b1;
    wb_err_d    = wb_err_q || (bus_io.wb_valid && !busy_q[bus_io.wb_destadd]);
    out_valid_d = accept ? 1'b1 : (bus_io.out_ready ? 1'b0 : out_valid_q);
    op1_d       = accept ? (byp1 ? bus_io.ALUout : bus_io.src1) : op1_q;
    op2_d       = accept ? (byp2 ? bus_io.ALUout : bus_io.src2) : op2_q;
    dest_d      = accept ? bus_io.in_destadd : dest_q;
    wen_d       = accept ? bus_io.in_wen : wen_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      dest_q      <= '0;
      wen_q       <= 1'b0;
      wb_err_q    <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      dest_q      <= dest_d;
      wen_q       <= wen_d;
      wb_err_q    <= wb_err_d;
    end
  end
  assign bus_io.in_ready    = ready;
  assign bus_io.srcadd1     = bus_io.in_srcadd1;
  assign bus_io.srcadd2     = bus_io.in_srcadd2;
  assign bus_io.out_valid   = out_valid_q;
  assign bus_io.op1         = op1_q;
  assign bus_io.op2         = op2_q;
  assign bus_io.out_destadd = dest_q;
  assign bus_io.out_wen     = wen_q;
  assign bus_io.wb_err      = wb_err_q;
endmodule
